register_array: RTL and testbench



---
 rtl/register_array_pkg.sv | 8 +
 rtl/reg_cell.sv | 21 ++
 rtl/register_array.sv | 47 ++++
 tb/tb_register_array.sv | 128 ++++++++++++
 4 files changed

// File: rtl/register_array_pkg.sv
// Shared helpers for the register bank: derived select-index width.
package register_array_pkg;

    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_cell.sv
// One DATA_WIDTH register with synchronous reset and load enable.
module reg_cell #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // Reset takes priority over any pending load.
    always_ff @(posedge clk) begin
        if (rst)
            q <= RESET_VALUE;
        else if (enable)
            q <= d;
    end

endmodule

// File: rtl/register_array.sv
// Bank of independently enabled registers on a shared write bus, with a
// flattened parallel read bus and a combinational single-register read port.
module register_array
    import register_array_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    NUM_REG     = 6,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    SEL_WIDTH   = sel_width(NUM_REG)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REG-1:0]            i_write_enable,
    input  logic [DATA_WIDTH-1:0]         i_write_data,
    input  logic [SEL_WIDTH-1:0]          i_read_sel,
    output logic [NUM_REG*DATA_WIDTH-1:0] o_read_data,
    output logic [DATA_WIDTH-1:0]         o_sel_data
);

    logic [NUM_REG-1:0][DATA_WIDTH-1:0] regs;

    for (genvar g = 0; g < NUM_REG; g++) begin : g_cell
        reg_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .RESET_VALUE(RESET_VALUE)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .enable(i_write_enable[g]),
            .d     (i_write_data),
            .q     (regs[g])
        );
    end

    // Packed element i already lands at bits [i*DATA_WIDTH +: DATA_WIDTH].
    assign o_read_data = regs;

    // Compare-and-select so indices past NUM_REG fall through to zero.
    always_comb begin
        o_sel_data = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            if (i_read_sel == i[SEL_WIDTH-1:0])
                o_sel_data = regs[i];
        end
    end

endmodule

// File: tb/tb_register_array.sv
// Scoreboard bench for register_array: a bench-side model predicts outputs per
// cycle, expectations are queued on drive and popped after the capturing edge.
module tb_register_array;

    localparam int DW = 8;
    localparam int NR = 6;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     we;
    logic [DW-1:0]     wd;
    logic [SW-1:0]     sel;
    logic [NR*DW-1:0]  rd;
    logic [DW-1:0]     sd;

    always #5 clk = ~clk;

    register_array #(
        .DATA_WIDTH (DW),
        .NUM_REG    (NR),
        .RESET_VALUE('0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_write_enable(we),
        .i_write_data  (wd),
        .i_read_sel    (sel),
        .o_read_data   (rd),
        .o_sel_data    (sd)
    );

    typedef struct packed {
        logic [NR*DW-1:0] rd;
        logic [DW-1:0]    sd;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mdl[NR];
    bit            primed = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_out(input logic [SW-1:0] s);
        exp_t x;
        for (int i = 0; i < NR; i++) x.rd[i*DW +: DW] = mdl[i];
        x.sd = (int'(s) < NR) ? mdl[s] : '0;
        return x;
    endfunction

    // One clock: drive, confirm no write-through before the edge, then
    // compare post-edge outputs against the queued prediction.
    task automatic step(input logic r, input logic [NR-1:0] e,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
        exp_t pre;
        exp_t post;
        rst = r; we = e; wd = d; sel = s;
        pre = model_out(s);
        for (int i = 0; i < NR; i++) begin
            if (r) mdl[i] = '0;
            else if (e[i]) mdl[i] = d;
        end
        sb.push_back(model_out(s));
        #1;
        if (primed) begin
            chk("pre_rd", rd, pre.rd);
            chk("pre_sd", sd, pre.sd);
        end
        @(posedge clk);
        #1;
        primed = 1'b1;
        post = sb.pop_front();
        chk("rd", rd, post.rd);
        chk("sd", sd, post.sd);
    endtask

    initial begin
        rst = 1'b0; we = '0; wd = '0; sel = '0;

        // Reset wins over a full-width write.
        step(1'b1, 6'b111111, 8'h55, 3'd0);
        chk("plan_reset", rd, 48'h0);

        step(1'b0, 6'b000001, 8'hAA, 3'd0);
        chk("plan_w1", rd, 48'h0000_0000_00AA);

        step(1'b0, 6'b000100, 8'hAA, 3'd2);
        chk("plan_w2", rd, 48'h0000_00AA_00AA);

        repeat (3) step(1'b0, 6'b000000, 8'h33, 3'd1);
        chk("plan_hold", rd, 48'h0000_00AA_00AA);

        step(1'b0, 6'b110000, 8'h3C, 3'd5);
        chk("plan_multi", rd, 48'h3C3C_00AA_00AA);

        // Select port is combinational; no clock needed.
        sel = 3'd2; #1; chk("sel2", sd, 8'hAA);
        sel = 3'd5; #1; chk("sel5", sd, 8'h3C);
        sel = 3'd7; #1; chk("sel7", sd, 8'h00);
        sel = 3'd6; #1; chk("sel6", sd, 8'h00);
        sel = 3'd0; #1; chk("sel0", sd, 8'hAA);
        sel = 3'd1; #1; chk("sel1", sd, 8'h00);

        @(negedge clk);
        step(1'b1, 6'b111111, 8'hFF, 3'd5);
        chk("plan_midrst", rd, 48'h0);
        chk("plan_midrst_sd", sd, 8'h00);

        for (int n = 0; n < 60; n++) begin
            step(($urandom_range(0, 15) == 0), NR'($urandom),
                 DW'($urandom), SW'($urandom_range(0, 7)));
        end

        if (sb.size() != 0) chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
